// File: rtl/capture_pkg.sv
// capture_pkg: shared types for the capture sequencer.
//   cap_state_e : FSM state encoding (3-bit, IDLE..DONE)
//   MODE_*      : trigger mode codes; code 3 behaves as MODE_EXT
package capture_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StPre  = 3'd1,
      StWait = 3'd2,
      StPost = 3'd3,
      StDone = 3'd4
   } cap_state_e;

   localparam logic [1:0] MODE_IMM  = 2'd0;
   localparam logic [1:0] MODE_EXT  = 2'd1;
   localparam logic [1:0] MODE_CONT = 2'd2;

endpackage

// File: rtl/capture_trig_cond.sv
// capture_trig_cond: trigger qualification for the capture sequencer.
// Ports:
//   clk, rst    : adc_clk and synchronous active-high reset
//   ext_trig    : external trigger level; a rising edge is a trigger request
//   in_pre      : sequencer is in PRE; edges here are lost, not kept
//   clear       : arm / auto re-arm; drops pending and trig_lost
//   enter_wait  : sequencer enters WAIT this cycle
//   wait_mode   : mode governing the capture being entered
//   consume     : trigger sample taken this cycle
//   pending     : trigger available to the current sample (includes same-cycle edge)
//   trig_lost   : sticky flag, edge seen during PRE
module capture_trig_cond
   import capture_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ext_trig,
   input  logic       in_pre,
   input  logic       clear,
   input  logic       enter_wait,
   input  logic [1:0] wait_mode,
   input  logic       consume,
   output logic       pending,
   output logic       trig_lost
);

   logic ext_q;
   logic pend_q;
   logic rise;
   logic force_pend;

   assign rise       = ext_trig & ~ext_q;
   assign pending    = pend_q | (rise & ~in_pre);
   // Immediate mode: the first sample seen in WAIT is the trigger.
   assign force_pend = enter_wait && (wait_mode == MODE_IMM);

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q     <= 1'b0;
         pend_q    <= 1'b0;
         trig_lost <= 1'b0;
      end else begin
         ext_q <= ext_trig;
         if (force_pend) begin
            pend_q <= 1'b1;
         end else if (clear || consume) begin
            pend_q <= 1'b0;
         end else begin
            pend_q <= pending;
         end
         if (clear) begin
            trig_lost <= 1'b0;
         end else if (rise && in_pre) begin
            trig_lost <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: multi-channel snapshot capture controller driving the
// capture RAM write port, with pre-trigger history and readout handshake.
// Ports:
//   clk, rst           : adc_clk, synchronous active-high reset
//   adc_data/adc_valid : channel samples (ch0 in LSBs) and strobe
//   mode, pretrig      : trigger mode and pre-trigger depth, latched on arm
//   chan_mask          : per-channel write enable, sampled on every write
//   arm, ext_trig      : start/restart pulse, external trigger level
//   ro_ack             : host finished readout (acted on in DONE only)
//   wr_en/wr_addr/wr_data/wr_mask : RAM write port (1-cycle latency)
//   state, running, full, trig_addr, trig_lost, cap_count : status
//   trig_time          : trigger timestamp
// Build option: define CAPTURE_TIMESTAMP_EN to include the free-running
// timestamp counter; otherwise trig_time is tied to 0.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int unsigned NCH = 8,
   parameter int unsigned DW  = 16,
   parameter int unsigned AW  = 14,
   parameter int unsigned CW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] adc_data,
   input  logic              adc_valid,
   input  logic [1:0]        mode,
   input  logic [AW-1:0]     pretrig,
   input  logic [NCH-1:0]    chan_mask,
   input  logic              arm,
   input  logic              ext_trig,
   input  logic              ro_ack,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [NCH*DW-1:0] wr_data,
   output logic [NCH-1:0]    wr_mask,
   output logic [2:0]        state,
   output logic              running,
   output logic              full,
   output logic [AW-1:0]     trig_addr,
   output logic              trig_lost,
   output logic [CW-1:0]     cap_count,
   output logic [31:0]       trig_time
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   cap_state_e  state_q;
   logic [AW-1:0] ptr_q;
   logic [AW-1:0] pre_cnt_q;
   logic [AW:0]   post_cnt_q;
   logic [1:0]    mode_q;
   logic [AW-1:0] pretrig_q;

   logic          restart;
   logic [1:0]    new_mode;
   logic [AW-1:0] new_pretrig;
   logic          enter_wait;
   logic          wr_valid;
   logic          trig_fire;
   logic          pending;
   logic [AW:0]   post_len;

   assign new_mode    = arm ? mode : mode_q;
   assign new_pretrig = arm ? pretrig : pretrig_q;
   assign restart     = arm || ((state_q == StDone) && ro_ack && (mode_q == MODE_CONT));
   assign running     = (state_q == StPre) || (state_q == StWait) || (state_q == StPost);
   // arm wins over a coincident sample: that sample is not written.
   assign wr_valid    = adc_valid && running && !arm;
   assign enter_wait  = (restart && (new_pretrig == '0)) ||
                        (!arm && (state_q == StPre) && adc_valid &&
                         ((pre_cnt_q + AW'(1)) == pretrig_q));
   assign trig_fire   = !arm && (state_q == StWait) && adc_valid && pending;
   // Samples written from the trigger on, trigger included.
   assign post_len    = DEPTH - {1'b0, pretrig_q};
   assign state       = state_q;

   capture_trig_cond u_trig_cond (
      .clk        (clk),
      .rst        (rst),
      .ext_trig   (ext_trig),
      .in_pre     (state_q == StPre),
      .clear      (restart),
      .enter_wait (enter_wait),
      .wait_mode  (new_mode),
      .consume    (trig_fire),
      .pending    (pending),
      .trig_lost  (trig_lost)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         mode_q     <= '0;
         pretrig_q  <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_mask    <= '0;
         full       <= 1'b0;
         trig_addr  <= '0;
         cap_count  <= '0;
      end else begin
         wr_en   <= 1'b0;
         wr_mask <= '0;
         if (restart) begin
            state_q   <= (new_pretrig == '0) ? StWait : StPre;
            ptr_q     <= '0;
            pre_cnt_q <= '0;
            full      <= 1'b0;
            mode_q    <= new_mode;
            pretrig_q <= new_pretrig;
         end else begin
            if (wr_valid) begin
               wr_en   <= 1'b1;
               wr_addr <= ptr_q;
               wr_data <= adc_data;
               wr_mask <= chan_mask;
               ptr_q   <= ptr_q + AW'(1);
            end
            unique case (state_q)
               StPre: begin
                  if (adc_valid) begin
                     pre_cnt_q <= pre_cnt_q + AW'(1);
                     if (enter_wait) state_q <= StWait;
                  end
               end
               StWait: begin
                  if (trig_fire) begin
                     trig_addr  <= ptr_q;
                     post_cnt_q <= (AW+1)'(1);
                     if (post_len == (AW+1)'(1)) begin
                        state_q   <= StDone;
                        full      <= 1'b1;
                        cap_count <= cap_count + CW'(1);
                     end else begin
                        state_q <= StPost;
                     end
                  end
               end
               StPost: begin
                  if (adc_valid) begin
                     post_cnt_q <= post_cnt_q + (AW+1)'(1);
                     if ((post_cnt_q + (AW+1)'(1)) == post_len) begin
                        state_q   <= StDone;
                        full      <= 1'b1;
                        cap_count <= cap_count + CW'(1);
                     end
                  end
               end
               StDone: begin
                  // Continuous mode re-arm is handled by restart above.
                  if (ro_ack) state_q <= StIdle;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CAPTURE_TIMESTAMP_EN
   logic [31:0] ts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q      <= '0;
         trig_time <= '0;
      end else begin
         ts_q <= ts_q + 32'd1;
         if (trig_fire) trig_time <= ts_q;
      end
   end
`else
   assign trig_time = '0;
`endif

endmodule
